mem_port_arbiter: RTL

- Shares the single memory port between three requesters: the MMU page-table walker, the load/store unit and instruction fetch.
- Fixed priority MMU > data > fetch, with an anti-starvation override for fetch.
- Flush support: an in-flight access completes on the memory side but its response is discarded.
- Sits between the MMU/pipeline and the memory model. Serialises all accesses, one outstanding at a time.

---
 rtl/mem_port_arbiter.sv | 227 ++++++++++++++++++++++
 1 files changed

// File: rtl/mem_port_arbiter.sv
// Memory port arbiter: shares one memory port between the page-table walker,
// the load/store unit and instruction fetch. One access is in flight at a time.
// Priority is MMU > data > fetch. A fetch that keeps losing is eventually
// forced to win. A flush lets the memory access finish but drops its response.
module mem_port_arbiter #(
    parameter int STARVE_LIMIT = 4,
    parameter int CNT_W        = 3
) (
    input  logic        clk_i,
    input  logic        rst_ni,
    input  logic        flush_i,
    input  logic        mmu_req_i,
    input  logic [33:0] mmu_addr_i,
    output logic        mmu_done_o,
    output logic        mmu_err_o,
    output logic [31:0] mmu_rdata_o,
    input  logic        if_req_i,
    input  logic [31:0] if_addr_i,
    output logic        if_done_o,
    output logic [31:0] if_rdata_o,
    input  logic        d_req_i,
    input  logic        d_we_i,
    input  logic [31:0] d_addr_i,
    input  logic [31:0] d_wdata_i,
    input  logic [3:0]  d_wstrb_i,
    output logic        d_done_o,
    output logic [31:0] d_rdata_o,
    output logic        mem_valid_o,
    output logic [31:0] mem_addr_o,
    output logic        mem_we_o,
    output logic [31:0] mem_wdata_o,
    output logic [3:0]  mem_wstrb_o,
    input  logic        mem_ready_i,
    input  logic [31:0] mem_rdata_i,
    output logic [1:0]  grant_id_o,
    output logic        busy_o
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        RESP  = 2'd2
    } state_e;

    localparam logic [1:0] GRANT_NONE  = 2'd0;
    localparam logic [1:0] GRANT_MMU   = 2'd1;
    localparam logic [1:0] GRANT_DATA  = 2'd2;
    localparam logic [1:0] GRANT_FETCH = 2'd3;

    localparam logic [CNT_W-1:0] STARVE_MAX = CNT_W'(STARVE_LIMIT);

    state_e           state_q,     state_d;
    logic [1:0]       grantId_q,   grantId_d;
    logic [31:0]      addr_q,      addr_d;
    logic             we_q,        we_d;
    logic [31:0]      wdata_q,     wdata_d;
    logic [3:0]       wstrb_q,     wstrb_d;
    logic             drop_q,      drop_d;
    logic [CNT_W-1:0] starveCnt_q, starveCnt_d;
    logic             mmuErr_q,    mmuErr_d;
    logic [31:0]      mmuRdata_q,  mmuRdata_d;
    logic [31:0]      ifRdata_q,   ifRdata_d;
    logic [31:0]      dRdata_q,    dRdata_d;

    logic [1:0]       winner;
    logic             respDone;

    // Pick the winner of an IDLE-cycle arbitration; a flush suppresses any grant.
    always_comb begin
        winner = GRANT_NONE;
        if (state_q == IDLE && !flush_i) begin
            if (if_req_i && starveCnt_q == STARVE_MAX) begin
                winner = GRANT_FETCH;
            end else if (mmu_req_i) begin
                winner = GRANT_MMU;
            end else if (d_req_i) begin
                winner = GRANT_DATA;
            end else if (if_req_i) begin
                winner = GRANT_FETCH;
            end
        end
    end

    // Next-state logic: latch the winner's request, track the memory handshake and route the response.
    always_comb begin
        state_d     = state_q;
        grantId_d   = grantId_q;
        addr_d      = addr_q;
        we_d        = we_q;
        wdata_d     = wdata_q;
        wstrb_d     = wstrb_q;
        drop_d      = drop_q;
        starveCnt_d = starveCnt_q;
        mmuErr_d    = mmuErr_q;
        mmuRdata_d  = mmuRdata_q;
        ifRdata_d   = ifRdata_q;
        dRdata_d    = dRdata_q;

        unique case (state_q)
            IDLE: begin
                if (!if_req_i || winner == GRANT_FETCH) begin
                    starveCnt_d = '0;
                end else if ((winner == GRANT_MMU || winner == GRANT_DATA) &&
                             starveCnt_q != STARVE_MAX) begin
                    starveCnt_d = starveCnt_q + CNT_W'(1);
                end

                case (winner)
                    GRANT_MMU: begin
                        grantId_d = GRANT_MMU;
                        addr_d    = mmu_addr_i[31:0];
                        we_d      = 1'b0;
                        wdata_d   = '0;
                        wstrb_d   = '0;
                        if (mmu_addr_i[33:32] != 2'b00) begin
                            mmuErr_d   = 1'b1;
                            mmuRdata_d = '0;
                            state_d    = RESP;
                        end else begin
                            state_d    = ISSUE;
                        end
                    end
                    GRANT_DATA: begin
                        grantId_d = GRANT_DATA;
                        addr_d    = d_addr_i;
                        we_d      = d_we_i;
                        wdata_d   = d_wdata_i;
                        wstrb_d   = d_we_i ? d_wstrb_i : 4'b0000;
                        state_d   = ISSUE;
                    end
                    GRANT_FETCH: begin
                        grantId_d = GRANT_FETCH;
                        addr_d    = if_addr_i;
                        we_d      = 1'b0;
                        wdata_d   = '0;
                        wstrb_d   = '0;
                        state_d   = ISSUE;
                    end
                    default: begin
                        state_d = IDLE;
                    end
                endcase
            end
            ISSUE: begin
                if (flush_i) begin
                    drop_d = 1'b1;
                end
                if (mem_ready_i) begin
                    if (drop_q || flush_i) begin
                        state_d   = IDLE;
                        grantId_d = GRANT_NONE;
                        drop_d    = 1'b0;
                    end else begin
                        case (grantId_q)
                            GRANT_MMU:   mmuRdata_d = mem_rdata_i;
                            GRANT_DATA:  dRdata_d   = mem_rdata_i;
                            GRANT_FETCH: ifRdata_d  = mem_rdata_i;
                            default:     ;
                        endcase
                        state_d = RESP;
                    end
                end
            end
            RESP: begin
                state_d   = IDLE;
                grantId_d = GRANT_NONE;
                mmuErr_d  = 1'b0;
                drop_d    = 1'b0;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and datapath registers, all cleared by the asynchronous reset.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q     <= IDLE;
            grantId_q   <= GRANT_NONE;
            addr_q      <= '0;
            we_q        <= 1'b0;
            wdata_q     <= '0;
            wstrb_q     <= '0;
            drop_q      <= 1'b0;
            starveCnt_q <= '0;
            mmuErr_q    <= 1'b0;
            mmuRdata_q  <= '0;
            ifRdata_q   <= '0;
            dRdata_q    <= '0;
        end else begin
            state_q     <= state_d;
            grantId_q   <= grantId_d;
            addr_q      <= addr_d;
            we_q        <= we_d;
            wdata_q     <= wdata_d;
            wstrb_q     <= wstrb_d;
            drop_q      <= drop_d;
            starveCnt_q <= starveCnt_d;
            mmuErr_q    <= mmuErr_d;
            mmuRdata_q  <= mmuRdata_d;
            ifRdata_q   <= ifRdata_d;
            dRdata_q    <= dRdata_d;
        end
    end

    // The done pulse lasts for the single RESP cycle and is suppressed by a dropped or flushed response.
    always_comb begin
        respDone   = (state_q == RESP) && !drop_q && !flush_i;
        mmu_done_o = respDone && (grantId_q == GRANT_MMU);
        d_done_o   = respDone && (grantId_q == GRANT_DATA);
        if_done_o  = respDone && (grantId_q == GRANT_FETCH);
    end

    assign mmu_err_o   = mmuErr_q;
    assign mmu_rdata_o = mmuRdata_q;
    assign if_rdata_o  = ifRdata_q;
    assign d_rdata_o   = dRdata_q;
    assign mem_valid_o = (state_q == ISSUE);
    assign mem_addr_o  = addr_q;
    assign mem_we_o    = we_q;
    assign mem_wdata_o = wdata_q;
    assign mem_wstrb_o = wstrb_q;
    assign grant_id_o  = grantId_q;
    assign busy_o      = (state_q != IDLE);

endmodule
